// File: rtl/iir8_pkg.sv
// Shared defaults, lane-slice helper macro and FSM state type for the IIR lane aligner.
`ifndef IIR8_PKG_SV
`define IIR8_PKG_SV

`define IIR8_LANE(vec, d, w) vec[(d)*(w) +: (w)]

package iir8_pkg;

  localparam int unsigned DEF_NLANES  = 8;
  localparam int unsigned DEF_DATA_W  = 24;
  localparam int unsigned DEF_DELAY_W = 5;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

endpackage

`endif

// File: rtl/iir_lane_align_shift.sv
// One aligner lane: free-running variable-tap shift register (no reset, SRL-friendly)
// followed by a reset-able output register.
module iir_lane_shift #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned DELAY_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_i,
  input  logic [DELAY_W-1:0] dly_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int unsigned DEPTH = 2 ** DELAY_W;

  logic [DATA_W-1:0] sr_q [DEPTH];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    sr_q[0] <= din_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      sr_q[i] <= sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (clr_i) begin
      dout_q <= '0;
    end else begin
      dout_q <= sr_q[dly_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/iir_lane_align.sv
// Per-lane programmable-delay aligner with valid tracking and settle/reload FSM.
// Optional feature macro: IIR_ALIGN_FLUSH_EN (flush valid history and blank dout on reload).
module iir_lane_align
  import iir8_pkg::*;
#(
  parameter int unsigned NLANES  = DEF_NLANES,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DELAY_W = DEF_DELAY_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NLANES*DATA_W-1:0]  din,
  input  logic                      din_valid,
  input  logic [NLANES*DELAY_W-1:0] dly_in,
  input  logic                      dly_load,
  output logic [NLANES*DATA_W-1:0]  dout,
  output logic                      dout_valid,
  output logic                      settling,
  output logic                      reload_err
);

  localparam int unsigned DEPTH = 2 ** DELAY_W;
  localparam logic [DELAY_W-1:0] CNT_MAX = DELAY_W'(DEPTH - 1);

  state_e                    state_q, state_d;
  logic [DELAY_W-1:0]        cnt_q, cnt_d;
  logic [NLANES*DELAY_W-1:0] dly_q, dly_d;
  logic [DEPTH-1:0]          vsr_q, vsr_d;
  logic                      dv_q, dv_d;
  logic                      err_q, err_d;
  logic [NLANES-1:0]         lane_ok;
  logic                      lane_clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (dly_load) begin
          dly_d   = dly_in;
          cnt_d   = CNT_MAX;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (dly_load) begin
          dly_d = dly_in;
          cnt_d = CNT_MAX;
          err_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // The incoming din_valid is always captured, even on the reload edge.
  always_comb begin
    vsr_d = {vsr_q[DEPTH-2:0], din_valid};
`ifdef IIR_ALIGN_FLUSH_EN
    if (dly_load) begin
      vsr_d    = '0;
      vsr_d[0] = din_valid;
    end
    lane_clr = (state_d == ST_SETTLE);
`else
    lane_clr = 1'b0;
`endif
  end

  // Valid uses next state so it drops on the load edge together with settling rising.
  assign dv_d = (state_d == ST_RUN) && (&lane_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      dly_q   <= '0;
      vsr_q   <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      vsr_q   <= vsr_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  for (genvar d = 0; d < NLANES; d++) begin : g_lane
    iir_lane_shift #(
      .DATA_W (DATA_W),
      .DELAY_W(DELAY_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .din_i (`IIR8_LANE(din, d, DATA_W)),
      .dly_i (`IIR8_LANE(dly_q, d, DELAY_W)),
      .clr_i (lane_clr),
      .dout_o(`IIR8_LANE(dout, d, DATA_W))
    );
    assign lane_ok[d] = vsr_q[`IIR8_LANE(dly_q, d, DELAY_W)];
  end

  assign dout_valid = dv_q;
  assign settling   = (state_q == ST_SETTLE);
  assign reload_err = err_q;

endmodule

// File: tb/tb_iir_lane_align.sv
// Self-checking bench for iir_lane_align: directed scenarios plus randomized traffic
// against a history-based reference model.
module tb_iir_lane_align;

  localparam int NL    = 8;
  localparam int DW    = 24;
  localparam int DLW   = 5;
  localparam int DEPTH = 32;
  localparam int HIST  = 2048;

  logic              clk;
  logic              rst_n;
  logic [NL*DW-1:0]  din;
  logic              din_valid;
  logic [NL*DLW-1:0] dly_in;
  logic              dly_load;
  logic [NL*DW-1:0]  dout;
  logic              dout_valid;
  logic              settling;
  logic              reload_err;

  iir_lane_align #(
    .NLANES (NL),
    .DATA_W (DW),
    .DELAY_W(DLW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .dly_in    (dly_in),
    .dly_load  (dly_load),
    .dout      (dout),
    .dout_valid(dout_valid),
    .settling  (settling),
    .reload_err(reload_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: input history indexed by edge number plus settle bookkeeping.
  logic [NL*DW-1:0]  hist_din [HIST];
  bit                hist_v   [HIST];
  int                ecount = 0;
  int                rem = 0;
  logic [NL*DLW-1:0] m_dly = '0;
  bit                m_err = 1'b0;
  logic [NL*DW-1:0]  exp_dout = '0;
  logic [NL*DW-1:0]  exp_mask = '0;
  bit                exp_dv = 1'b0;

  task automatic chkv(input string tag, input logic [NL*DW-1:0] got, input logic [NL*DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int  t;
    int  idx;
    bit  allv;
    t = ecount;
    hist_din[t] = din;
    if (!rst_n) begin
      for (int i = 0; i < HIST; i++) hist_v[i] = 1'b0;
      m_dly    = '0;
      rem      = 0;
      m_err    = 1'b0;
      exp_dout = '0;
      exp_mask = '1;
      exp_dv   = 1'b0;
    end else begin
      hist_v[t] = din_valid;
      allv      = 1'b1;
      exp_dout  = '0;
      exp_mask  = '0;
      for (int d = 0; d < NL; d++) begin
        idx = t - 1 - int'(m_dly[d*DLW +: DLW]);
        if (idx < 0) begin
          allv = 1'b0;
        end else begin
          exp_dout[d*DW +: DW] = hist_din[idx][d*DW +: DW];
          exp_mask[d*DW +: DW] = '1;
          allv = allv & hist_v[idx];
        end
      end
      if (dly_load) begin
        if (rem > 0) m_err = 1'b1;
        rem   = DEPTH;
        m_dly = dly_in;
`ifdef IIR_ALIGN_FLUSH_EN
        for (int i = 0; i < t; i++) hist_v[i] = 1'b0;
`endif
      end else if (rem > 0) begin
        rem--;
      end
      exp_dv = (rem == 0) && allv;
`ifdef IIR_ALIGN_FLUSH_EN
      if (rem > 0) begin
        exp_dout = '0;
        exp_mask = '1;
      end
`endif
    end
    ecount++;
  endtask

  task automatic step(input logic [NL*DW-1:0] d, input logic v, input logic ld,
                      input logic [NL*DLW-1:0] dl);
    din       = d;
    din_valid = v;
    dly_load  = ld;
    dly_in    = dl;
    @(posedge clk);
    model_edge();
    #1;
    chk1("dout_valid", dout_valid, exp_dv);
    chk1("settling", settling, rem > 0);
    chk1("reload_err", reload_err, m_err);
    chkv("dout", dout & exp_mask, exp_dout & exp_mask);
  endtask

  function automatic logic [NL*DW-1:0] rnd_din();
    logic [NL*DW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [NL*DLW-1:0] rnd_dly();
    return (NL*DLW)'({$urandom, $urandom});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL*DW-1:0]  v;
    logic [NL*DLW-1:0] dl;
    int n;

    rst_n = 1'b0; din = '0; din_valid = 1'b0; dly_in = '0; dly_load = 1'b0;
    repeat (3) step('0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    chkv("reset_dout", dout, '0);
    chk1("reset_dv", dout_valid, 1'b0);
    chk1("reset_settling", settling, 1'b0);
    chk1("reset_err", reload_err, 1'b0);

    // 1: zero delay -> one-cycle latency
    v = '0; v[DW-1:0] = DW'(100);
    step(v, 1'b1, 1'b0, '0);
    chk1("t1_dv_early", dout_valid, 1'b0);
    step('0, 1'b0, 1'b0, '0);
    chkv("t1_dout_lane0", {{(NL-1)*DW{1'b0}}, dout[DW-1:0]}, {{(NL-1)*DW{1'b0}}, DW'(100)});
    chk1("t1_dv", dout_valid, 1'b1);

    // 2: staggered delays 7-d, impulse on all lanes
    dl = '0;
    for (int d = 0; d < NL; d++) dl[d*DLW +: DLW] = DLW'(7 - d);
    step('0, 1'b0, 1'b1, dl);
    repeat (33) step('0, 1'b0, 1'b0, dl);
    chk1("t2_settled", settling, 1'b0);
    v = '0;
    for (int d = 0; d < NL; d++) v[d*DW +: DW] = DW'(100);
    step(v, 1'b1, 1'b0, dl);
    for (int j = 1; j <= 9; j++) begin
      step('0, 1'b0, 1'b0, dl);
      v = '0;
      for (int d = 0; d < NL; d++) if (j == 8 - d) v[d*DW +: DW] = DW'(100);
      chkv("t2_impulse", dout, v);
      chk1("t2_dv_low", dout_valid, 1'b0);
    end
    for (int j = 0; j < 10; j++) begin
      step(rnd_din(), 1'b1, 1'b0, dl);
      chk1("t2_dv_all_taps", dout_valid, j >= 8);
    end

    // 3: maximum delay, ramp -> 32-cycle latency, no drops/dups
    dl = '1;
    step('0, 1'b0, 1'b1, dl);
    repeat (33) step('0, 1'b0, 1'b0, dl);
    for (int i = 0; i < 64; i++) begin
      v = '0;
      for (int d = 0; d < NL; d++) v[d*DW +: DW] = DW'(i*8 + d);
      step(v, 1'b1, 1'b0, dl);
      if (i == 31) chk1("t3_dv_before", dout_valid, 1'b0);
      if (i >= 32) begin
        v = '0;
        for (int d = 0; d < NL; d++) v[d*DW +: DW] = DW'((i-32)*8 + d);
        chkv("t3_ramp", dout, v);
        chk1("t3_dv", dout_valid, 1'b1);
      end
    end

    // 4: settle length, then reload at settle cycle 10
    dl = rnd_dly();
    step(rnd_din(), 1'b1, 1'b1, dl);
    n = settling ? 1 : 0;
    for (int k = 0; k < 100 && settling; k++) begin
      chk1("t4_dv_settle", dout_valid, 1'b0);
`ifdef IIR_ALIGN_FLUSH_EN
      chkv("t4_flush_dout", dout, '0);
`endif
      step(rnd_din(), 1'b1, 1'b0, dl);
      if (settling) n++;
    end
    chki("t4_settle_len", n, 32);
    chk1("t4_no_err", reload_err, 1'b0);
    step(rnd_din(), 1'b1, 1'b1, dl);
    n = 1;
    for (int k = 1; k < 200; k++) begin
      step(rnd_din(), 1'b1, k == 10, dl);
      if (!settling) break;
      n++;
    end
    chki("t4_reload_len", n, 42);
    chk1("t4_err", reload_err, 1'b1);

    // 5: asynchronous reset mid-settle
    step(rnd_din(), 1'b1, 1'b1, rnd_dly());
    repeat (5) step(rnd_din(), 1'b1, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    chkv("t5_async_dout", dout, '0);
    chk1("t5_async_dv", dout_valid, 1'b0);
    chk1("t5_async_settling", settling, 1'b0);
    chk1("t5_async_err", reload_err, 1'b0);
    step(rnd_din(), 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    v = '0; v[DW-1:0] = DW'(55);
    step(v, 1'b1, 1'b0, '0);
    chk1("t5_dv_early", dout_valid, 1'b0);
    step(rnd_din(), 1'b0, 1'b0, '0);
    chk1("t5_dv", dout_valid, 1'b1);
    chkv("t5_dout_lane0", {{(NL-1)*DW{1'b0}}, dout[DW-1:0]}, {{(NL-1)*DW{1'b0}}, DW'(55)});

    // Randomized traffic with occasional reloads
    for (int i = 0; i < 600; i++) begin
      step(rnd_din(), ($urandom_range(9, 0) < 8), ($urandom_range(39, 0) == 0), rnd_dly());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
